// File: rtl/rr_mux_16to1_16b.sv
// Round-robin 16:1 multiplexer for 16-bit words with valid/ready on every port.
// Multi-word packets keep the grant from their first beat through in_last.
// The selected word lands in a registered output stage that supports
// load-while-drain for one word per cycle.
module rr_mux_16to1_16b #(
  parameter int WIDTH = 16,
  parameter int N     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [3:0]         out_sel,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]       state_q,     state_d;
  logic [3:0]       ptr_q,       ptr_d;
  logic [3:0]       lock_idx_q,  lock_idx_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [3:0]       out_sel_q,   out_sel_d;
  logic             out_last_q,  out_last_d;
  logic             out_valid_q, out_valid_d;

  logic       load_en;
  logic       cand_found;
  logic [3:0] cand_idx;
  logic [3:0] scan_idx;
  logic [3:0] sel_idx;
  logic       sel_ok;
  logic       xfer;

  // Rotating-priority scan: first requesting source at or after ptr, wrapping.
  always_comb begin
    cand_idx   = '0;
    cand_found = 1'b0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      scan_idx = ptr_q + 4'(k);
      if (!cand_found && in_valid[scan_idx]) begin
        cand_idx   = scan_idx;
        cand_found = 1'b1;
      end
    end
  end

  // Grant selection and source handshake; a held lock excludes everyone else.
  always_comb begin
    load_en = !out_valid_q || out_ready;
    if (state_q == LOCK) begin
      sel_idx = lock_idx_q;
      sel_ok  = in_valid[lock_idx_q];
    end else begin
      sel_idx = cand_idx;
      sel_ok  = cand_found;
    end
    xfer     = load_en && sel_ok;
    in_ready = '0;
    if (xfer && rst_n) begin
      in_ready[sel_idx] = 1'b1;
    end
  end

  // Next-state: output register load, pointer advance and lock tracking.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_idx_d  = lock_idx_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = in_data[int'(sel_idx)*WIDTH +: WIDTH];
      out_sel_d   = sel_idx;
      out_last_d  = in_last[sel_idx];
      out_valid_d = 1'b1;
      if (in_last[sel_idx]) begin
        ptr_d   = sel_idx + 4'd1;
        state_d = ARB;
      end else begin
        lock_idx_d = sel_idx;
        state_d    = LOCK;
      end
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      ptr_q       <= '0;
      lock_idx_q  <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_idx_q  <= lock_idx_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_16to1_16b.sv
// Bench for rr_mux_16to1_16b: per-source word FIFOs feed the DUT; a
// transaction-level model predicts grants and the registered output.
module tb_rr_mux_16to1_16b;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [255:0] in_data = '0;
  logic [15:0]  in_valid = '0;
  logic [15:0]  in_last = '0;
  logic [15:0]  in_ready;
  logic [15:0]  out_data;
  logic [3:0]   out_sel;
  logic         out_last;
  logic         out_valid;
  logic         out_ready = 1'b1;

  always #5 clk = ~clk;

  rr_mux_16to1_16b #(.WIDTH(16), .N(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int checks = 0;
  int failures = 0;

  // Per-source pending words {last, data}
  logic [16:0] fifo [16][64];
  int          head [16];
  int          cnt  [16];

  // Reference model state
  int          m_ptr;
  int          m_lock;   // -1 when no packet in progress
  logic        m_ov;
  logic [15:0] m_od;
  logic [3:0]  m_os;
  logic        m_ol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input int s, input logic [15:0] d, input logic l);
    if (cnt[s] < 64) begin
      fifo[s][(head[s] + cnt[s]) % 64] = {l, d};
      cnt[s]++;
    end
  endfunction

  function automatic void clear_all();
    for (int s = 0; s < 16; s++) begin
      head[s] = 0;
      cnt[s]  = 0;
    end
  endfunction

  function automatic void drive_inputs();
    for (int s = 0; s < 16; s++) begin
      in_valid[s] = (cnt[s] > 0);
      if (cnt[s] > 0) begin
        in_data[s*16 +: 16] = fifo[s][head[s]][15:0];
        in_last[s]          = fifo[s][head[s]][16];
      end
    end
  endfunction

  function automatic void model_reset();
    m_ptr  = 0;
    m_lock = -1;
    m_ov   = 1'b0;
    m_od   = '0;
    m_os   = '0;
    m_ol   = 1'b0;
  endfunction

  // Which source should be accepted this cycle, as a one-hot mask
  function automatic logic [15:0] model_ready();
    logic [15:0] r;
    r = '0;
    if (rst_n && (!m_ov || out_ready)) begin
      if (m_lock >= 0) begin
        if (in_valid[m_lock]) r[m_lock] = 1'b1;
      end else begin
        for (int k = 0; k < 16; k++) begin
          if (r == '0 && in_valid[(m_ptr + k) % 16]) r[(m_ptr + k) % 16] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  function automatic void model_step(input logic [15:0] r);
    int g;
    g = -1;
    for (int i = 0; i < 16; i++) if (r[i]) g = i;
    if (g >= 0) begin
      m_od = in_data[g*16 +: 16];
      m_os = 4'(g);
      m_ol = in_last[g];
      m_ov = 1'b1;
      if (m_ol) begin
        m_ptr  = (g + 1) % 16;
        m_lock = -1;
      end else begin
        m_lock = g;
      end
      head[g] = (head[g] + 1) % 64;
      cnt[g]--;
    end else if (!m_ov || out_ready) begin
      m_ov = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    chk("out_valid", out_valid, m_ov);
    chk("out_data",  out_data,  m_od);
    chk("out_sel",   out_sel,   m_os);
    chk("out_last",  out_last,  m_ol);
  endtask

  // One cycle: drive, check in_ready before the edge, check outputs after it
  task automatic tick();
    logic [15:0] r;
    drive_inputs();
    #1;
    r = model_ready();
    chk("in_ready", in_ready, r);
    @(posedge clk);
    model_step(r);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    drive_inputs();
    #1;
    model_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready",  in_ready,  16'h0000);
    check_outputs();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int seq5 [4];
    clear_all();
    model_reset();
    #1;

    // Reset with every source requesting; first grant after release is 0
    for (int i = 0; i < 16; i++) push(i, 16'h2000 + 16'(i), 1'b1);
    do_reset();
    tick();
    chk("t1_first_sel", out_sel, 4'd0);
    chk("t1_first_data", out_data, 16'h2000);
    clear_all();
    tick();
    tick();

    // Single source
    push(5, 16'hA5A5, 1'b1);
    tick();
    chk("t2_valid", out_valid, 1'b1);
    chk("t2_data", out_data, 16'hA5A5);
    chk("t2_sel", out_sel, 4'd5);
    chk("t2_last", out_last, 1'b1);
    tick();
    chk("t2_idle", out_valid, 1'b0);

    // Round-robin over all sources, no bubbles, wraps 15 -> 0
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(i, 16'h1000 + 16'(i), 1'b1);
      push(i, 16'h1000 + 16'(i), 1'b1);
    end
    for (int i = 0; i < 17; i++) begin
      tick();
      chk("t3_valid", out_valid, 1'b1);
      chk("t3_sel", out_sel, 32'(i % 16));
      chk("t3_data", out_data, 32'(16'h1000 + 16'(i % 16)));
    end
    clear_all();

    // Back-pressure holds outputs and blocks sources
    do_reset();
    for (int i = 0; i < 16; i++) push(i, 16'h1000 + 16'(i), 1'b1);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("t4_sel_before", out_sel, 4'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_hold_sel", out_sel, 4'd2);
      chk("t4_hold_data", out_data, 16'h1002);
      chk("t4_hold_valid", out_valid, 1'b1);
      chk("t4_hold_ready", in_ready, 16'h0000);
    end
    out_ready = 1'b1;
    tick();
    chk("t4_resume_sel", out_sel, 4'd3);
    chk("t4_resume_data", out_data, 16'h1003);
    clear_all();

    // Packet lock: source 3's three beats precede source 4
    do_reset();
    push(3, 16'h0031, 1'b0);
    push(3, 16'h0032, 1'b0);
    push(3, 16'h0033, 1'b1);
    push(4, 16'h0041, 1'b1);
    seq5 = '{3, 3, 3, 4};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_sel", out_sel, 32'(seq5[i]));
    end
    chk("t5_last_data", out_data, 16'h0041);
    tick();

    // Async reset in the middle of a locked packet from source 7
    push(7, 16'h0071, 1'b0);
    push(7, 16'h0072, 1'b0);
    push(7, 16'h0073, 1'b1);
    push(9, 16'h0091, 1'b1);
    tick();
    chk("t6_beat1", out_sel, 4'd7);
    tick();
    chk("t6_beat2", out_data, 16'h0072);
    do_reset();
    chk("t6_rst_valid", out_valid, 1'b0);
    tick();
    chk("t6_after_sel", out_sel, 4'd7);
    chk("t6_after_data", out_data, 16'h0073);
    tick();
    chk("t6_next_sel", out_sel, 4'd9);
    tick();

    // Randomized traffic: packets of 1..3 beats, random sink stalls, rare resets
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int s;
        int len;
        s   = int'($urandom_range(0, 15));
        len = int'($urandom_range(1, 3));
        if (cnt[s] < 50) begin
          for (int b = 0; b < len; b++) push(s, 16'($urandom), (b == len - 1));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 400; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
